ysyx_23060208_rd_arbiter: RTL

Two-master, one-slave read-channel arbiter. It shares the single data/instruction SRAM AR/R channels between IFU instruction fetch and EXU load accesses. Exactly one read is outstanding at a time, and grant is locked from AR issue until the R handshake completes. The EXU write channels (AW/W/B) bypass this block and connect to the SRAM directly, since AXI read and write channels are independent.

---
 rtl/ysyx_23060208_rd_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ysyx_23060208_rd_arbiter.sv
// Two-master (IFU, EXU) read-channel arbiter in front of one SRAM AR/R port.
// Optional round-robin tie-break: define YSYX_23060208_ARB_RR_EN (default: EXU wins ties).
module ysyx_23060208_rd_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] ifu_araddr,
  input  logic                  ifu_arvalid,
  output logic                  ifu_arready,
  output logic [DATA_WIDTH-1:0] ifu_rdata,
  output logic [1:0]            ifu_rresp,
  output logic                  ifu_rvalid,
  input  logic                  ifu_rready,
  input  logic [ADDR_WIDTH-1:0] exu_araddr,
  input  logic                  exu_arvalid,
  output logic                  exu_arready,
  output logic [DATA_WIDTH-1:0] exu_rdata,
  output logic [1:0]            exu_rresp,
  output logic                  exu_rvalid,
  input  logic                  exu_rready,
  output logic [ADDR_WIDTH-1:0] sram_araddr,
  output logic                  sram_arvalid,
  input  logic                  sram_arready,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  input  logic [1:0]            sram_rresp,
  input  logic                  sram_rvalid,
  output logic                  sram_rready,
  output logic [1:0]            arb_grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   gnt, gnt_nxt;
  logic   tie_gnt;
  logic   own_arvalid;
  logic   own_rready;
  logic [ADDR_WIDTH-1:0] own_araddr;

`ifdef YSYX_23060208_ARB_RR_EN
  logic last_gnt, last_gnt_nxt;
  assign tie_gnt = ~last_gnt;
`else
  assign tie_gnt = 1'b1;
`endif

  assign own_arvalid = gnt ? exu_arvalid : ifu_arvalid;
  assign own_araddr  = gnt ? exu_araddr  : ifu_araddr;
  assign own_rready  = gnt ? exu_rready  : ifu_rready;

  // Read data and response are broadcast; only rvalid is steered.
  assign ifu_rdata = sram_rdata;
  assign exu_rdata = sram_rdata;
  assign ifu_rresp = sram_rresp;
  assign exu_rresp = sram_rresp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 1'b0;
`ifdef YSYX_23060208_ARB_RR_EN
      last_gnt <= 1'b1;
`endif
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
`ifdef YSYX_23060208_ARB_RR_EN
      last_gnt <= last_gnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
`ifdef YSYX_23060208_ARB_RR_EN
    last_gnt_nxt = last_gnt;
`endif
    sram_araddr  = ifu_araddr;
    sram_arvalid = 1'b0;
    sram_rready  = 1'b0;
    ifu_arready  = 1'b0;
    exu_arready  = 1'b0;
    ifu_rvalid   = 1'b0;
    exu_rvalid   = 1'b0;
    arb_grant    = 2'b00;
    case (state)
      IDLE: begin
        // Decision is registered; nothing reaches the SRAM this cycle.
        if (ifu_arvalid && exu_arvalid) begin
          gnt_nxt   = tie_gnt;
          state_nxt = ADDR;
        end else if (exu_arvalid) begin
          gnt_nxt   = 1'b1;
          state_nxt = ADDR;
        end else if (ifu_arvalid) begin
          gnt_nxt   = 1'b0;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        sram_araddr  = own_araddr;
        sram_arvalid = own_arvalid;
        ifu_arready  = ~gnt & sram_arready;
        exu_arready  = gnt & sram_arready;
        arb_grant    = {gnt, ~gnt};
        // A master withdrawing its request un-locks the grant without issuing.
        if (!own_arvalid) begin
          state_nxt = IDLE;
        end else if (sram_arready) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        ifu_rvalid  = ~gnt & sram_rvalid;
        exu_rvalid  = gnt & sram_rvalid;
        sram_rready = own_rready;
        arb_grant   = {gnt, ~gnt};
        if (sram_rvalid && own_rready) begin
          state_nxt    = IDLE;
`ifdef YSYX_23060208_ARB_RR_EN
          last_gnt_nxt = gnt;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
